mem_port_arbiter: RTL and testbench

//  Shares the single core-side memory port between instruction fetch (IF, read-only) and
//  the MEM stage (load/store). Sequences one bus transaction at a time and generates
//  if_stall_req / mem_stall_req for hazard_unit. MEM has priority; a starvation counter

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single core-side memory port between instruction fetch and the MEM stage.
// One bus transaction is in flight at a time; MEM wins ties unless IF has been starved too long.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic [1:0]          if_req_size,
  input  logic                if_kill,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_rdata,
  output logic                if_stall_req,
  input  logic                mem_req_valid,
  input  logic                mem_req_wen,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic [1:0]          mem_req_size,
  output logic                mem_resp_valid,
  output logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                mem_stall_req,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_wen,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wmask,
  output logic [1:0]          bus_req_size,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {G_NONE, G_IF, G_MEM} grant_t;

  state_t           state_q;
  state_t           state_d;
  grant_t           grant_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             kill_pend;
  logic             start;
  logic             pick_if;
  logic             resp_done;

  assign start     = (state_q == S_IDLE) && (if_req_valid || mem_req_valid);
  assign pick_if   = if_req_valid && (!mem_req_valid || starve_cnt == LIMIT);
  assign resp_done = (state_q == S_WAIT) && bus_resp_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)          state_d = S_ISSUE;
      S_ISSUE: if (bus_req_ready)  state_d = S_WAIT;
      S_WAIT:  if (bus_resp_valid) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Grant, starvation count and a registered copy of the winner's request fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q       <= G_NONE;
      starve_cnt    <= '0;
      kill_pend     <= 1'b0;
      bus_req_wen   <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wmask <= '0;
      bus_req_size  <= '0;
    end else begin
      if (start) begin
        if (pick_if) begin
          grant_q       <= G_IF;
          starve_cnt    <= '0;
          bus_req_wen   <= 1'b0;
          bus_req_addr  <= if_req_addr;
          bus_req_wdata <= '0;
          bus_req_wmask <= '0;
          bus_req_size  <= if_req_size;
        end else begin
          grant_q <= G_MEM;
          if (if_req_valid && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
          bus_req_wen   <= mem_req_wen;
          bus_req_addr  <= mem_req_addr;
          bus_req_wdata <= mem_req_wdata;
          bus_req_wmask <= mem_req_wmask;
          bus_req_size  <= mem_req_size;
        end
      end else if (resp_done) begin
        grant_q <= G_NONE;
      end

      // A killed fetch still drains on the bus; only its response is swallowed.
      if (resp_done)
        kill_pend <= 1'b0;
      else if (if_kill && grant_q == G_IF && state_q != S_IDLE)
        kill_pend <= 1'b1;
    end
  end

  always_comb begin
    bus_req_valid  = (state_q == S_ISSUE);
    if_resp_valid  = resp_done && (grant_q == G_IF) && !kill_pend && !if_kill;
    mem_resp_valid = resp_done && (grant_q == G_MEM);
    if_resp_rdata  = if_resp_valid  ? bus_resp_rdata : '0;
    mem_resp_rdata = mem_resp_valid ? bus_resp_rdata : '0;
    if_stall_req   = if_req_valid  && !if_resp_valid;
    mem_stall_req  = mem_req_valid && !mem_resp_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 64;
  localparam int DATA_W       = 64;
  localparam int STARVE_LIMIT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req_valid;
  logic [63:0]       if_req_addr;
  logic [1:0]        if_req_size;
  logic              if_kill;
  logic              if_resp_valid;
  logic [63:0]       if_resp_rdata;
  logic              if_stall_req;
  logic              mem_req_valid;
  logic              mem_req_wen;
  logic [63:0]       mem_req_addr;
  logic [63:0]       mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic [1:0]        mem_req_size;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_rdata;
  logic              mem_stall_req;
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_wen;
  logic [63:0]       bus_req_addr;
  logic [63:0]       bus_req_wdata;
  logic [7:0]        bus_req_wmask;
  logic [1:0]        bus_req_size;
  logic              bus_resp_valid;
  logic [63:0]       bus_resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_size(if_req_size),
    .if_kill(if_kill), .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .if_stall_req(if_stall_req),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_size(mem_req_size),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_stall_req(mem_stall_req),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
    .bus_req_size(bus_req_size), .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; if_req_addr = '0; if_req_size = '0; if_kill = 0;
    mem_req_valid = 0; mem_req_wen = 0; mem_req_addr = '0; mem_req_wdata = '0;
    mem_req_wmask = '0; mem_req_size = '0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    n_checks++;
    if ({bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_size,
         if_resp_valid, if_resp_rdata, if_stall_req, mem_resp_valid, mem_resp_rdata,
         mem_stall_req} !== '0)
      $display("[TB] FAIL reset_outputs: bus_valid=%b addr=%h if_stall=%b mem_stall=%b expected all 0",
               bus_req_valid, bus_req_addr, if_stall_req, mem_stall_req);
    else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    sample();
    n_checks++;
    if ({bus_req_valid, if_resp_valid, mem_resp_valid, if_stall_req, mem_stall_req} !== 5'b0)
      $display("[TB] FAIL idle_after_reset: got %b expected 00000",
               {bus_req_valid, if_resp_valid, mem_resp_valid, if_stall_req, mem_stall_req});
    else n_pass++;
  endtask

  task automatic test_if_only();
    do_reset();
    bus_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0000; if_req_size = 2'd2;
    sample();
    n_checks++;
    if ({bus_req_valid, if_stall_req, if_resp_valid} !== 3'b010)
      $display("[TB] FAIL if_only_req_cycle: valid/stall/resp=%b expected 010",
               {bus_req_valid, if_stall_req, if_resp_valid});
    else n_pass++;
    tick(); sample();
    n_checks++;
    if ({bus_req_valid, bus_req_wen, bus_req_size, bus_req_addr} !== {1'b1, 1'b0, 2'd2, 64'h8000_0000})
      $display("[TB] FAIL if_only_issue: valid=%b wen=%b size=%0d addr=%h expected 1 0 2 80000000",
               bus_req_valid, bus_req_wen, bus_req_size, bus_req_addr);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick(); sample();
      n_checks++;
      if ({bus_req_valid, if_resp_valid, if_stall_req} !== 3'b001)
        $display("[TB] FAIL if_only_wait%0d: valid/resp/stall=%b expected 001", i,
                 {bus_req_valid, if_resp_valid, if_stall_req});
      else n_pass++;
    end
    tick();
    bus_resp_valid = 1; bus_resp_rdata = 64'h13;
    sample();
    n_checks++;
    if ({if_resp_valid, if_stall_req, if_resp_rdata} !== {1'b1, 1'b0, 64'h13})
      $display("[TB] FAIL if_only_resp: resp=%b stall=%b rdata=%h expected 1 0 13",
               if_resp_valid, if_stall_req, if_resp_rdata);
    else n_pass++;
    tick();
    bus_resp_valid = 0; if_req_valid = 0;
    sample();
    n_checks++;
    if ({bus_req_valid, if_resp_valid, if_stall_req} !== 3'b000)
      $display("[TB] FAIL if_only_done: valid/resp/stall=%b expected 000",
               {bus_req_valid, if_resp_valid, if_stall_req});
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    bus_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0004; if_req_size = 2'd2;
    mem_req_valid = 1; mem_req_wen = 0; mem_req_addr = 64'h8000_1000; mem_req_size = 2'd3;
    sample();
    n_checks++;
    if ({if_stall_req, mem_stall_req, bus_req_valid} !== 3'b110)
      $display("[TB] FAIL prio_stalls: if/mem stall,valid=%b expected 110",
               {if_stall_req, mem_stall_req, bus_req_valid});
    else n_pass++;
    tick(); sample();
    n_checks++;
    if ({bus_req_valid, bus_req_wen, bus_req_addr} !== {1'b1, 1'b0, 64'h8000_1000})
      $display("[TB] FAIL prio_mem_first: valid=%b wen=%b addr=%h expected 1 0 80001000",
               bus_req_valid, bus_req_wen, bus_req_addr);
    else n_pass++;
    tick();
    bus_resp_valid = 1; bus_resp_rdata = 64'hAAAA_5555_0000_1111;
    sample();
    n_checks++;
    if ({mem_resp_valid, mem_stall_req, if_resp_valid, if_stall_req, mem_resp_rdata} !==
        {4'b1001, 64'hAAAA_5555_0000_1111})
      $display("[TB] FAIL prio_mem_resp: mresp/mstall/iresp/istall=%b rdata=%h expected 1001 aaaa555500001111",
               {mem_resp_valid, mem_stall_req, if_resp_valid, if_stall_req}, mem_resp_rdata);
    else n_pass++;
    tick();
    bus_resp_valid = 0; mem_req_valid = 0;
    tick(); sample();
    n_checks++;
    if ({bus_req_valid, bus_req_addr} !== {1'b1, 64'h8000_0004})
      $display("[TB] FAIL prio_if_second: valid=%b addr=%h expected 1 80000004",
               bus_req_valid, bus_req_addr);
    else n_pass++;
    tick();
    bus_resp_valid = 1; bus_resp_rdata = 64'h0000_0013_0000_0093;
    sample();
    n_checks++;
    if ({if_resp_valid, mem_resp_valid, if_resp_rdata} !== {2'b10, 64'h0000_0013_0000_0093})
      $display("[TB] FAIL prio_if_resp: iresp/mresp=%b rdata=%h expected 10 0000001300000093",
               {if_resp_valid, mem_resp_valid}, if_resp_rdata);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    bit   exp_if [4];
    logic got_if;
    exp_if = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    bus_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0008; if_req_size = 2'd2;
    mem_req_valid = 1; mem_req_wen = 0; mem_req_addr = 64'h9000_0000; mem_req_size = 2'd3;
    for (int t = 0; t < 4; t++) begin
      tick(); sample();
      got_if = (bus_req_addr === if_req_addr);
      n_checks++;
      if ({bus_req_valid, got_if} !== {1'b1, exp_if[t]})
        $display("[TB] FAIL starve_grant%0d: valid=%b is_if=%b expected 1 %b", t,
                 bus_req_valid, got_if, exp_if[t]);
      else n_pass++;
      tick();
      bus_resp_valid = 1; bus_resp_rdata = {32'(t), 32'hCAFE_0000};
      sample();
      n_checks++;
      if ({if_resp_valid, mem_resp_valid} !== (exp_if[t] ? 2'b10 : 2'b01))
        $display("[TB] FAIL starve_route%0d: if/mem resp=%b expected %b", t,
                 {if_resp_valid, mem_resp_valid}, exp_if[t] ? 2'b10 : 2'b01);
      else n_pass++;
      tick();
      bus_resp_valid = 0;
      if (exp_if[t]) if_req_addr = if_req_addr + 64'd4;
      else           mem_req_addr = mem_req_addr + 64'd8;
    end
    clear_inputs();
  endtask

  task automatic test_kill();
    do_reset();
    bus_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0040; if_req_size = 2'd2;
    tick(); sample();
    n_checks++;
    if ({bus_req_valid, bus_req_addr} !== {1'b1, 64'h8000_0040})
      $display("[TB] FAIL kill_issue: valid=%b addr=%h expected 1 80000040", bus_req_valid, bus_req_addr);
    else n_pass++;
    tick();
    if_kill = 1;
    sample();
    tick();
    if_kill = 0; if_req_addr = 64'h8000_0100;
    bus_resp_valid = 1; bus_resp_rdata = 64'hDEAD;
    sample();
    n_checks++;
    if ({if_resp_valid, if_stall_req} !== 2'b01)
      $display("[TB] FAIL kill_suppress: resp/stall=%b expected 01", {if_resp_valid, if_stall_req});
    else n_pass++;
    tick();
    bus_resp_valid = 0;
    tick(); sample();
    n_checks++;
    if ({bus_req_valid, bus_req_addr} !== {1'b1, 64'h8000_0100})
      $display("[TB] FAIL kill_refetch: valid=%b addr=%h expected 1 80000100", bus_req_valid, bus_req_addr);
    else n_pass++;
    tick();
    bus_resp_valid = 1; bus_resp_rdata = 64'h0010_0073;
    sample();
    n_checks++;
    if ({if_resp_valid, if_stall_req, if_resp_rdata} !== {2'b10, 64'h0010_0073})
      $display("[TB] FAIL kill_new_data: resp/stall=%b rdata=%h expected 10 100073",
               {if_resp_valid, if_stall_req}, if_resp_rdata);
    else n_pass++;
    tick();
    clear_inputs();
    bus_req_ready = 1;
    mem_req_valid = 1; mem_req_addr = 64'h8000_3000; mem_req_size = 2'd3;
    tick();
    tick();
    if_kill = 1; bus_resp_valid = 1; bus_resp_rdata = 64'h55;
    sample();
    n_checks++;
    if ({mem_resp_valid, mem_resp_rdata} !== {1'b1, 64'h55})
      $display("[TB] FAIL kill_ignored_mem: resp=%b rdata=%h expected 1 55", mem_resp_valid, mem_resp_rdata);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_store_backpressure();
    do_reset();
    bus_req_ready = 0;
    mem_req_valid = 1; mem_req_wen = 1; mem_req_addr = 64'h8000_2000;
    mem_req_wdata = 64'h1122_3344_5566_7788; mem_req_wmask = 8'h0F; mem_req_size = 2'd3;
    tick();
    for (int i = 0; i < 4; i++) begin
      sample();
      n_checks++;
      if ({bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_size, mem_stall_req}
          !== {1'b1, 1'b1, 64'h8000_2000, 64'h1122_3344_5566_7788, 8'h0F, 2'd3, 1'b1})
        $display("[TB] FAIL store_hold%0d: valid=%b wen=%b addr=%h wdata=%h wmask=%h size=%0d stall=%b expected 1 1 80002000 1122334455667788 0f 3 1",
                 i, bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_size, mem_stall_req);
      else n_pass++;
      tick();
    end
    bus_req_ready = 1;
    tick();
    bus_req_ready = 0; bus_resp_valid = 1; bus_resp_rdata = '0;
    sample();
    n_checks++;
    if ({mem_resp_valid, mem_stall_req, bus_req_valid} !== 3'b100)
      $display("[TB] FAIL store_ack: resp/stall/valid=%b expected 100",
               {mem_resp_valid, mem_stall_req, bus_req_valid});
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0200; if_req_size = 2'd2;
    tick();
    tick();
    #2;
    reset = 1; if_req_valid = 0; bus_req_ready = 0;
    #1;
    n_checks++;
    if ({bus_req_valid, bus_req_wen, bus_req_addr, bus_req_size, if_resp_valid, if_stall_req,
         mem_resp_valid, mem_stall_req} !== '0)
      $display("[TB] FAIL reset_midflight: valid=%b addr=%h size=%0d if_stall=%b expected all 0",
               bus_req_valid, bus_req_addr, bus_req_size, if_stall_req);
    else n_pass++;
    tick();
    reset = 0;
    bus_req_ready = 1;
    if_req_valid = 1; if_req_addr = 64'h8000_0300;
    tick(); sample();
    n_checks++;
    if ({bus_req_valid, bus_req_addr} !== {1'b1, 64'h8000_0300})
      $display("[TB] FAIL reset_reissue: valid=%b addr=%h expected 1 80000300", bus_req_valid, bus_req_addr);
    else n_pass++;
    tick();
    bus_resp_valid = 1; bus_resp_rdata = 64'h0000_0297;
    sample();
    n_checks++;
    if ({if_resp_valid, if_resp_rdata} !== {1'b1, 64'h0000_0297})
      $display("[TB] FAIL reset_resp: resp=%b rdata=%h expected 1 297", if_resp_valid, if_resp_rdata);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  // Reference model: one transaction record, free again the cycle after its response.
  task automatic test_random();
    bit          busy, accepted, t_if, t_wen, take_if;
    int          issue_at, free_from, starve;
    logic [63:0] t_addr, t_wdata;
    logic [7:0]  t_wmask;
    logic [1:0]  t_size;
    bit          exp_valid, exp_resp, exp_if_resp, exp_mem_resp;
    bit          env_out, n_resp, n_ready, if_next, mem_next;
    int          env_wait;
    busy = 0; accepted = 0; t_if = 0; t_wen = 0; issue_at = 0; free_from = 0; starve = 0;
    t_addr = '0; t_wdata = '0; t_wmask = '0; t_size = '0; env_out = 0; env_wait = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      sample();
      if (!busy && cyc >= free_from && (if_req_valid || mem_req_valid)) begin
        take_if = if_req_valid && (!mem_req_valid || starve >= STARVE_LIMIT);
        if (take_if) begin
          starve = 0;
          t_if = 1; t_wen = 0; t_addr = if_req_addr; t_size = if_req_size;
          t_wdata = '0; t_wmask = '0;
        end else begin
          if (if_req_valid && starve < STARVE_LIMIT) starve++;
          t_if = 0; t_wen = mem_req_wen; t_addr = mem_req_addr; t_size = mem_req_size;
          t_wdata = mem_req_wdata; t_wmask = mem_req_wmask;
        end
        busy = 1; accepted = 0; issue_at = cyc + 1;
      end
      exp_valid    = busy && !accepted && cyc >= issue_at;
      exp_resp     = busy && accepted && bus_resp_valid;
      exp_if_resp  = exp_resp && t_if;
      exp_mem_resp = exp_resp && !t_if;
      n_checks++;
      if ({bus_req_valid, if_resp_valid, mem_resp_valid, if_stall_req, mem_stall_req} !==
          {exp_valid, exp_if_resp, exp_mem_resp, if_req_valid & ~exp_if_resp, mem_req_valid & ~exp_mem_resp})
        $display("[TB] FAIL rand_ctrl cyc%0d: valid/iresp/mresp/istall/mstall=%b expected %b", cyc,
                 {bus_req_valid, if_resp_valid, mem_resp_valid, if_stall_req, mem_stall_req},
                 {exp_valid, exp_if_resp, exp_mem_resp, if_req_valid & ~exp_if_resp, mem_req_valid & ~exp_mem_resp});
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if ({bus_req_wen, bus_req_addr, bus_req_size} !== {t_wen, t_addr, t_size})
          $display("[TB] FAIL rand_fields cyc%0d: wen=%b addr=%h size=%0d expected %b %h %0d", cyc,
                   bus_req_wen, bus_req_addr, bus_req_size, t_wen, t_addr, t_size);
        else n_pass++;
        if (t_wen) begin
          n_checks++;
          if ({bus_req_wdata, bus_req_wmask} !== {t_wdata, t_wmask})
            $display("[TB] FAIL rand_store cyc%0d: wdata=%h wmask=%h expected %h %h", cyc,
                     bus_req_wdata, bus_req_wmask, t_wdata, t_wmask);
          else n_pass++;
        end
      end
      if (exp_if_resp) begin
        n_checks++;
        if (if_resp_rdata !== bus_resp_rdata)
          $display("[TB] FAIL rand_if_data cyc%0d: rdata=%h expected %h", cyc, if_resp_rdata, bus_resp_rdata);
        else n_pass++;
      end
      if (exp_mem_resp) begin
        n_checks++;
        if (mem_resp_rdata !== bus_resp_rdata)
          $display("[TB] FAIL rand_mem_data cyc%0d: rdata=%h expected %h", cyc, mem_resp_rdata, bus_resp_rdata);
        else n_pass++;
      end
      if (exp_valid && bus_req_ready) accepted = 1;
      if (exp_resp) begin
        busy = 0;
        free_from = cyc + 1;
      end

      // Environment for the next cycle: bus responder and both requesters.
      if (bus_req_valid && bus_req_ready) begin
        env_out = 1;
        env_wait = $urandom_range(0, 2);
      end
      n_resp = 0;
      if (env_out) begin
        if (env_wait == 0) begin
          n_resp = 1;
          env_out = 0;
        end else env_wait--;
      end
      n_ready  = 1'($urandom_range(0, 1));
      if_next  = if_req_valid && !if_resp_valid;
      mem_next = mem_req_valid && !mem_resp_valid;
      tick();
      bus_req_ready  = n_ready;
      bus_resp_valid = n_resp;
      bus_resp_rdata = {$urandom, $urandom};
      if (!if_next) begin
        if_req_valid = 1'($urandom_range(0, 1));
        if_req_addr  = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
        if_req_size  = 2'd2;
      end
      if (!mem_next) begin
        mem_req_valid = 1'($urandom_range(0, 1));
        mem_req_wen   = 1'($urandom_range(0, 1));
        mem_req_addr  = 64'h8001_0000 + 64'($urandom_range(0, 255)) * 64'd8;
        mem_req_wdata = {$urandom, $urandom};
        mem_req_wmask = 8'($urandom);
        mem_req_size  = 2'($urandom);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_priority();
    test_starvation();
    test_kill();
    test_store_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
